// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter and its output decimator.
// Holds the default sample width, the default decimation exponent and the
// sample/accumulator types that both blocks exchange.
package iir_pkg;

    localparam int unsigned IIR_DW         = 8;
    localparam int unsigned IIR_DECIM_LOG2 = 2;

    typedef logic signed [IIR_DW-1:0]                sample_t;
    typedef logic signed [IIR_DW+IIR_DECIM_LOG2-1:0] acc_t;

endpackage

// File: rtl/iir_out_fifo.sv
// Two-entry first-word-fall-through FIFO for decimated samples.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   push          write push_data (ignored when full unless pop is also taken)
//   push_data     sample to store
//   pop           remove the head entry (ignored when empty)
//   head_data     oldest entry, registered
//   valid         FIFO non-empty
//   full          FIFO holds two entries
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int unsigned DW = IIR_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          valid,
    output logic          full
);

    // Shift-register organisation: head_q is always the oldest entry, so the
    // output comes straight from a flop.
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_pop;

    assign do_pop = pop && (cnt_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = push_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && do_pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    cnt_d  = 2'd2;
                end else if (do_pop) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                // A push without a pop is dropped here; the parent flags it.
                if (do_pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_data = head_q;
    assign valid     = (cnt_q != 2'd0);
    assign full      = (cnt_q == 2'd2);

endmodule

// File: rtl/iir_decimator.sv
// Block-averaging decimator behind the IIR filter. Sums 2^DECIM_LOG2 enabled
// samples, emits their average into a 2-entry FIFO and hands it out through
// a valid/ready port. A result arriving at a full FIFO with no pop is dropped
// and latches the sticky overflow flag.
// Build option: define ROUND_EN for round-half-up averaging; otherwise the
// average is floored by a plain arithmetic shift.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   en, y_in      sample strobe and signed filter sample
//   out_data      averaged sample at the FIFO head
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts out_data
//   overflow      sticky drop indicator
//   clr_ovf       synchronous clear of overflow (a same-edge drop wins)
module iir_decimator
    import iir_pkg::*;
#(
    parameter int unsigned DW         = IIR_DW,
    parameter int unsigned DECIM_LOG2 = IIR_DECIM_LOG2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic signed [DW-1:0] y_in,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int unsigned AW = DW + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
    localparam logic [DECIM_LOG2-1:0] CNT_ONE  = 1;

    logic signed [AW-1:0]    acc_q, acc_d;
    logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [AW-1:0]    sum;
    logic [DW-1:0]           result;
    logic                    block_end;
    logic                    pop;
    logic                    fifo_full;
    logic                    drop;
    logic [DW-1:0]           head_data;

    assign block_end = en && (cnt_q == CNT_LAST);
    assign pop       = out_valid && out_ready;
    // A push into a full FIFO survives only if the head leaves on this edge.
    assign drop      = block_end && fifo_full && !pop;

    always_comb begin
        sum = acc_q + {{DECIM_LOG2{y_in[DW-1]}}, y_in};
`ifdef ROUND_EN
        begin : g_round
            localparam logic [AW:0] HALF = (AW+1)'(1) << (DECIM_LOG2 - 1);
            logic signed [AW:0] sum_r;
            sum_r  = {sum[AW-1], sum} + HALF;
            result = DW'(sum_r >>> DECIM_LOG2);
        end
`else
        result = DW'(sum >>> DECIM_LOG2);
`endif
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (en) begin
            if (block_end) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    iir_out_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (block_end),
        .push_data (result),
        .pop       (pop),
        .head_data (head_data),
        .valid     (out_valid),
        .full      (fifo_full)
    );

    assign out_data = head_data;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_iir_decimator.sv
module tb_iir_decimator;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic signed [7:0] y_in;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
    logic              clr_ovf;

    int total = 0;
    int bad   = 0;

    // Reference state: q mirrors the expected FIFO contents, oldest first.
    int q[$];
    int m_acc;
    int m_cnt;
    bit m_ovf;

    typedef struct {
        int s0, s1, s2, s3;
        int exp_floor;
        int exp_round;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    iir_decimator #(
        .DW         (8),
        .DECIM_LOG2 (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .y_in      (y_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    function automatic int fdiv4(input int a);
        return (a >= 0) ? a / 4 : -((-a + 3) / 4);
    endfunction

    function automatic int avg4(input int sum);
`ifdef ROUND_EN
        return fdiv4(sum + 2);
`else
        return fdiv4(sum);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
        if (q.size() != 0) chk("out_data", int'(out_data), q[0]);
    endtask

    task automatic model_edge(input bit e, input int y, input bit r, input bit c);
        bit p;
        bit blk;
        int res;
        p   = (q.size() != 0) && r;
        blk = e && (m_cnt == 3);
        res = 0;
        if (e) begin
            if (blk) begin
                res   = avg4(m_acc + y);
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_acc += y;
                m_cnt++;
            end
        end
        if (p) void'(q.pop_front());
        if (blk && q.size() == 2) m_ovf = 1'b1;
        else begin
            if (blk) q.push_back(res);
            if (c) m_ovf = 1'b0;
        end
    endtask

    // One clock: check the state left by the previous edge, then drive the
    // inputs for the next edge and advance the reference.
    task automatic step(input bit e, input int y, input bit r, input bit c);
        @(negedge clk);
        check_outputs();
        en        = e;
        y_in      = y[7:0];
        out_ready = r;
        clr_ovf   = c;
        model_edge(e, y, r, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en        = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        q.delete();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        m_acc     = 0;
        m_cnt     = 0;
        m_ovf     = 1'b0;

        tbl[0] = '{1, 2, 3, 4, 2, 3};
        tbl[1] = '{-1, -1, -1, -2, -2, -1};
        tbl[2] = '{127, 127, 127, 126, 126, 127};
        tbl[3] = '{-128, -128, -128, -128, -128, -128};

        #12;
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_overflow", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Constant 5 with a ready consumer: one result per four samples.
        for (int i = 0; i < 12; i++) step(1, 5, 1, 0);
        step(0, 0, 1, 0);

        // Table of four-sample blocks with known averages.
        for (int i = 0; i < 4; i++) begin
            step(1, tbl[i].s0, 0, 0);
            step(1, tbl[i].s1, 0, 0);
            step(1, tbl[i].s2, 0, 0);
            step(1, tbl[i].s3, 0, 0);
            step(0, 0, 0, 0);
`ifdef ROUND_EN
            chk("tbl_avg", int'(out_data), tbl[i].exp_round);
`else
            chk("tbl_avg", int'(out_data), tbl[i].exp_floor);
`endif
            step(0, 0, 1, 0);
        end

        // Stalled consumer: two results held, third dropped.
        for (int i = 0; i < 12; i++) step(1, 7, 0, 0);
        step(0, 0, 0, 0);
        chk("stall_overflow", int'(overflow), 1);
        chk("stall_head", int'(out_data), 7);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("drained", int'(out_valid), 0);

        // Full FIFO with a pop on the block-end edge: no drop.
        for (int i = 0; i < 11; i++) step(1, 3, 0, 0);
        step(1, 3, 1, 0);
        step(0, 0, 0, 0);
        chk("pushpop_overflow", int'(overflow), 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("pushpop_two_left", int'(out_valid), 0);

        // Gaps in the enable hold the partial block.
        step(1, -128, 1, 0);
        step(0, 55, 1, 0);
        step(0, -3, 1, 0);
        step(1, -128, 1, 0);
        step(1, -128, 1, 0);
        step(0, 0, 1, 0);
        chk("gap_not_yet", int'(out_valid), 0);
        step(1, -128, 0, 0);
        step(0, 0, 0, 0);
        chk("gap_result", int'(out_data), -128);
        step(0, 0, 1, 0);

        // Reset mid-block with a full FIFO and overflow set.
        for (int i = 0; i < 14; i++) step(1, 9, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_reset_ovf", int'(overflow), 1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 9, 1, 0);
        step(0, 0, 1, 0);
        chk("post_reset_partial", int'(out_valid), 0);
        step(1, 9, 0, 0);
        step(0, 0, 0, 0);
        chk("post_reset_result", int'(out_data), 9);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
